spi_word_slave: RTL and testbench
=================================

SPI_WORD_SLAVE -- requirements
Module: spi_word_slave

Interface
REQ-001 Parameter DATA_W, default 8: bits per SPI word, legal range 4..32.
REQ-002 Parameter CPOL, default 0: sck idle level.
REQ-003 Parameter CPHA, default 0: 0 = sample on the leading edge; 1 = sample on the trailing edge.
REQ-004 Parameter MSB_FIRST, default 1: 1 = MSB first on both lines; 0 = LSB first.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  system clock, the only clock; SHALL run at least 4x the sck frequency.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 sck  input  1  SPI clock from master; asynchronous to clk.
REQ-009 mosi  input  1  master-to-slave data; asynchronous.
REQ-010 cs_n  input  1  chip select, active low; asynchronous.
REQ-011 miso  output  1  slave-to-master data, registered in clk.
REQ-012 rx_data  output  DATA_W  last accepted received word.
REQ-013 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-014 rx_ready  input  1  consumer accepts rx_data.
REQ-015 tx_data  input  DATA_W  next word to transmit.
REQ-016 tx_valid  input  1  tx_data offered.
REQ-017 tx_ready  output  1  TX holding register empty.
REQ-018 busy  output  1  synchronised cs_n is active.
REQ-019 overrun  output  1  one-clk pulse: received word dropped.
REQ-020 underrun  output  1  one-clk pulse: word load found the holding register empty.
REQ-021 frame_err  output  1  one-clk pulse: cs_n deasserted mid-word.

Function
REQ-022 sck, mosi and cs_n SHALL each pass through a 2-flop synchroniser; sck edges SHALL be detected by comparing the synchronised sck with a one-clk-delayed copy.
REQ-023 Leading edge = a transition away from CPOL; trailing edge = a transition back to CPOL; the sample edge is leading if CPHA=0 and trailing if CPHA=1; the shift edge is the other one.
REQ-024 sck edges SHALL be ignored while synchronised cs_n is high.
REQ-025 Each sample edge SHALL shift synchronised mosi into rx_shift (direction per MSB_FIRST) and increment bit_cnt; bit_cnt SHALL wrap DATA_W-1 -> 0.
REQ-026 The sample edge with bit_cnt==DATA_W-1 completes a word: the assembled word SHALL be written to rx_data and rx_valid set on the same clk edge that registers the detection.
REQ-027 Latency: rx_valid SHALL rise exactly 3 clk rising edges after the first clk edge that samples the final sck sample edge.
REQ-028 rx_valid SHALL stay high until a cycle with rx_valid && rx_ready, and SHALL clear on the next clk edge.
REQ-029 Word completion while rx_valid is high and rx_ready is low: the new word SHALL be dropped, rx_data unchanged, and overrun pulsed.
REQ-030 Word completion in the same cycle as a handshake: the new word SHALL load, rx_valid SHALL stay 1, and overrun SHALL stay 0.
REQ-031 tx_ready SHALL equal !hold_full; tx_valid && tx_ready SHALL capture tx_data into the holding register.
REQ-032 Load event: the holding register moves into tx_shift and is emptied; if the holding register is empty, tx_shift loads zeros and underrun pulses.
REQ-033 Load events, CPHA=0: on cs_n assertion detect, and on the shift edge that follows a word's final sample.
REQ-034 Load events, CPHA=1: the first shift edge of each word (bit_cnt==0).
REQ-035 Every other shift edge SHALL advance tx_shift by one bit.
REQ-036 miso SHALL present tx_shift's first-out bit while busy, and 0 while not busy.
REQ-037 A load event coinciding with a tx handshake SHALL use the prior holding contents; the newly offered word SHALL occupy the holding register.
REQ-038 On cs_n deassertion detect with bit_cnt!=0: bit_cnt SHALL go to 0, the partial word SHALL be discarded, frame_err SHALL pulse, the unsent tx_shift contents SHALL be lost, and the holding register SHALL be kept.
REQ-039 Consecutive words within one cs_n frame SHALL be supported with no gap required.

Reset
REQ-040 While rst_n is low: miso, rx_data, rx_valid, busy, overrun, underrun, frame_err, bit_cnt and the shift registers SHALL be 0; tx_ready SHALL be 1; the sck synchroniser SHALL be CPOL; the cs_n synchroniser SHALL be 1.
REQ-041 Reset mid-frame SHALL abort the frame without a frame_err pulse; the block SHALL resume on the next cs_n assertion after release.

Verification
REQ-042 Mode 0, DATA_W=8: holding=0xA5; master sends 0x3C -> rx_data=0x3C, rx_valid after 3 clk, master receives 0xA5.
REQ-043 Modes 1/2/3 with MSB_FIRST=0, DATA_W=16: send 0x1234, holding=0xBEEF -> rx_data=0x1234, master reads 0xBEEF in each mode.
REQ-044 Frame of two words 0x11, 0x22 with rx_ready=0 -> rx_data=0x11, overrun pulses once, rx_valid stays 1.
REQ-045 Empty holding at frame start -> underrun pulses, master reads 0x00.
REQ-046 cs_n released after 5 bits -> frame_err pulses, no rx_valid; next full frame 0x5A is received correctly.
REQ-047 rst_n low mid-word -> all outputs match REQ-040 immediately; no spurious rx_valid after release.

Source files
------------

// File: rtl/spi_word_slave.sv
// SPI word slave: oversamples sck/mosi/cs_n in clk, assembles DATA_W-bit words
// and shifts a double-buffered transmit word out on miso.
module spi_word_slave #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CPOL      = 0,
    parameter int unsigned CPHA      = 0,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              overrun,
    output logic              underrun,
    output logic              frame_err
);
    localparam int unsigned   CW   = $clog2(DATA_W);
    localparam logic          IDLE = (CPOL != 0);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [1:0]        sck_sync;
    logic [1:0]        mosi_sync;
    logic [1:0]        cs_sync;
    logic              sck_d;
    logic              cs_d;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;

    logic              active;
    logic              lead_ev;
    logic              trail_ev;
    logic              sample_ev;
    logic              shift_ev;
    logic              cs_fall;
    logic              cs_rise;
    logic              word_done;
    logic              load_ev;
    logic              rx_hs;
    logic              tx_hs;
    logic              tx_bit;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= {2{IDLE}};
            sck_d     <= IDLE;
            mosi_sync <= '0;
            cs_sync   <= '1;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[0], sck};
            sck_d     <= sck_sync[1];
            mosi_sync <= {mosi_sync[0], mosi};
            cs_sync   <= {cs_sync[0], cs_n};
            cs_d      <= cs_sync[1];
        end
    end

    always_comb begin
        active    = !cs_sync[1];
        lead_ev   = active && (sck_sync[1] != sck_d) && (sck_sync[1] != IDLE);
        trail_ev  = active && (sck_sync[1] != sck_d) && (sck_sync[1] == IDLE);
        sample_ev = (CPHA != 0) ? trail_ev : lead_ev;
        shift_ev  = (CPHA != 0) ? lead_ev  : trail_ev;
        cs_fall   = cs_d && !cs_sync[1];
        cs_rise   = !cs_d && cs_sync[1];
        word_done = sample_ev && (bit_cnt == LAST);
        // bit_cnt==0 on a shift edge marks a word boundary in both phases
        load_ev   = (shift_ev && (bit_cnt == '0)) || ((CPHA == 0) && cs_fall);
        rx_hs     = rx_valid && rx_ready;
        tx_hs     = tx_valid && !hold_full;
        if (MSB_FIRST != 0) begin
            rx_next = {rx_shift[DATA_W-2:0], mosi_sync[1]};
            tx_next = {tx_shift[DATA_W-2:0], 1'b0};
            tx_bit  = tx_shift[DATA_W-1];
        end else begin
            rx_next = {mosi_sync[1], rx_shift[DATA_W-1:1]};
            tx_next = {1'b0, tx_shift[DATA_W-1:1]};
            tx_bit  = tx_shift[0];
        end
    end

    assign tx_ready = !hold_full;
    assign busy     = active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            miso      <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
            miso      <= active ? tx_bit : 1'b0;

            if (cs_rise) begin
                if (bit_cnt != '0) begin
                    bit_cnt   <= '0;
                    rx_shift  <= '0;
                    tx_shift  <= '0;
                    frame_err <= 1'b1;
                end
            end else begin
                if (sample_ev) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
                end
                if (load_ev) begin
                    tx_shift <= hold_full ? hold_data : '0;
                    underrun <= !hold_full;
                end else if (shift_ev) begin
                    tx_shift <= tx_next;
                end
            end

            // a handshake in the completing cycle frees the slot for the new word
            if (word_done) begin
                if (!rx_valid || rx_hs) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (rx_hs) begin
                rx_valid <= 1'b0;
            end

            if (tx_hs) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end else if (load_ev) begin
                hold_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_word_slave.sv
// Bench for spi_word_slave: four instances (mode 0 8-bit MSB-first, modes 1..3
// 16-bit LSB-first) driven by a bit-level SPI master model.
`timescale 1ns/1ps
module tb_spi_word_slave;
    localparam int H = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  sck, mosi, cs_n, rx_ready, tx_valid;
    logic [15:0] tx_d [4];
    wire  [3:0]  miso, rx_valid, tx_ready, busy, overrun, underrun, frame_err;
    wire  [15:0] rx_w [4];
    wire  [7:0]  rx_d0;
    assign rx_w[0] = {8'h00, rx_d0};

    spi_word_slave #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u_m0 (
        .clk(clk), .rst_n(rst_n), .sck(sck[0]), .mosi(mosi[0]), .cs_n(cs_n[0]),
        .miso(miso[0]), .rx_data(rx_d0), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
        .tx_data(tx_d[0][7:0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .busy(busy[0]), .overrun(overrun[0]), .underrun(underrun[0]), .frame_err(frame_err[0]));

    for (genvar g = 1; g < 4; g++) begin : g_m
        spi_word_slave #(.DATA_W(16), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(0)) u_dut (
            .clk(clk), .rst_n(rst_n), .sck(sck[g]), .mosi(mosi[g]), .cs_n(cs_n[g]),
            .miso(miso[g]), .rx_data(rx_w[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
            .tx_data(tx_d[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
            .busy(busy[g]), .overrun(overrun[g]), .underrun(underrun[g]), .frame_err(frame_err[g]));
    end

    int passed = 0;
    int total  = 0;

    typedef struct packed { logic [1:0] inst; logic [15:0] data; } rx_ev_t;
    rx_ev_t rxq[$];
    int ovr_n[4], und_n[4], fer_n[4];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (overrun[i])   ovr_n[i]++;
            if (underrun[i])  und_n[i]++;
            if (frame_err[i]) fer_n[i]++;
            if (rx_valid[i] && rx_ready[i]) rxq.push_back({2'(i), rx_w[i]});
        end
    end

    // transmit holding-register model: one slot, loads empty it or count an underrun
    logic        mh_full [4];
    logic [15:0] mh_data [4];
    int          mdl_und;

    function automatic void mdl_offer(int m, logic [15:0] w);
        mh_full[m] = 1'b1;
        mh_data[m] = w;
    endfunction

    function automatic logic [15:0] mdl_load(int m);
        if (mh_full[m]) begin
            mh_full[m] = 1'b0;
            return mh_data[m];
        end
        mdl_und++;
        return 16'h0000;
    endfunction

    function automatic int wbits(int m);
        return (m == 0) ? 8 : 16;
    endfunction

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_on(int m);
        cs_n[m] = 1'b0;
        wait_clk(H);
    endtask

    task automatic cs_off(int m);
        cs_n[m] = 1'b1;
        wait_clk(H);
    endtask

    task automatic offer(int m, logic [15:0] w);
        int n = 0;
        while (!tx_ready[m] && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!tx_ready[m]) $display("FAIL offer_ready m%0d: tx_ready got %b expected 1", m, tx_ready[m]);
        else begin
            passed++;
            tx_d[m] = w;
            tx_valid[m] = 1'b1;
            @(negedge clk);
            tx_valid[m] = 1'b0;
        end
    endtask

    // SPI master: drives nbits of wout, captures miso just before each sample edge;
    // lat = first negedge count after the final sample edge where rx_valid is seen
    task automatic xfer(int m, int nbits, logic [15:0] wout, output logic [15:0] win, output int lat);
        int  w   = wbits(m);
        bit  pol = (m >= 2);
        bit  pha = (m % 2 == 1);
        win = '0;
        lat = 0;
        for (int k = 0; k < nbits; k++) begin
            int idx = (m == 0) ? w - 1 - k : k;
            if (!pha) begin
                mosi[m] = wout[idx];
                wait_clk(H);
                win[idx] = miso[m];
                sck[m] = ~pol;
            end else begin
                sck[m] = ~pol;
                mosi[m] = wout[idx];
                wait_clk(H);
                win[idx] = miso[m];
                sck[m] = pol;
            end
            for (int n = 1; n <= H; n++) begin
                @(negedge clk);
                if (k == w - 1 && lat == 0 && rx_valid[m]) lat = n;
            end
            if (!pha) begin
                sck[m] = pol;
                wait_clk(H);
            end
        end
        wait_clk(H);
    endtask

    task automatic test_reset();
        wait_clk(3);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({miso[i], rx_valid[i], busy[i], overrun[i], underrun[i], frame_err[i], tx_ready[i]} !== 7'b0000001)
                $display("FAIL reset_flags m%0d: got %b expected 0000001", i,
                         {miso[i], rx_valid[i], busy[i], overrun[i], underrun[i], frame_err[i], tx_ready[i]});
            else passed++;
            total++;
            if (rx_w[i] !== 16'h0000) $display("FAIL reset_rx_data m%0d: got %h expected 0000", i, rx_w[i]);
            else passed++;
        end
        rst_n = 1'b1;
        wait_clk(2);
    endtask

    task automatic test_mode0();
        logic [15:0] rd;
        int lat, u0;
        rx_ready[0] = 1'b0;
        offer(0, 16'h00A5);
        u0 = und_n[0];
        cs_on(0);
        total++;
        if (busy[0] !== 1'b1) $display("FAIL mode0_busy: got %b expected 1", busy[0]); else passed++;
        xfer(0, 8, 16'h003C, rd, lat);
        total++;
        if (lat !== 3) $display("FAIL mode0_latency: got %0d expected 3", lat); else passed++;
        total++;
        if (rx_valid[0] !== 1'b1 || rx_w[0] !== 16'h003C)
            $display("FAIL mode0_rx: got valid=%b data=%h expected valid=1 data=003c", rx_valid[0], rx_w[0]);
        else passed++;
        total++;
        if (rd !== 16'h00A5) $display("FAIL mode0_miso: got %h expected 00a5", rd); else passed++;
        cs_off(0);
        total++;
        if (und_n[0] - u0 !== 1) $display("FAIL mode0_end_underrun: got %0d expected 1", und_n[0] - u0); else passed++;
        total++;
        if (busy[0] !== 1'b0 || miso[0] !== 1'b0)
            $display("FAIL mode0_idle: got busy=%b miso=%b expected 0 0", busy[0], miso[0]);
        else passed++;
        rx_ready[0] = 1'b1;
        wait_clk(2);
        rx_ready[0] = 1'b0;
        total++;
        if (rx_valid[0] !== 1'b0) $display("FAIL mode0_consume: got %b expected 0", rx_valid[0]); else passed++;
    endtask

    task automatic test_modes_lsb();
        logic [15:0] rd;
        int lat, u0;
        rx_ev_t ev;
        rxq.delete();
        for (int m = 1; m < 4; m++) begin
            rx_ready[m] = 1'b1;
            offer(m, 16'hBEEF);
            u0 = und_n[m];
            cs_on(m);
            xfer(m, 16, 16'h1234, rd, lat);
            cs_off(m);
            total++;
            if (rd !== 16'hBEEF) $display("FAIL lsb_miso m%0d: got %h expected beef", m, rd); else passed++;
            total++;
            if (rxq.size() == 0) $display("FAIL lsb_rx m%0d: got no word expected 1234", m);
            else begin
                ev = rxq.pop_front();
                if (ev.inst !== 2'(m) || ev.data !== 16'h1234)
                    $display("FAIL lsb_rx m%0d: got inst=%0d data=%h expected inst=%0d data=1234", m, ev.inst, ev.data, m);
                else passed++;
            end
            total++;
            if (und_n[m] - u0 !== ((m % 2 == 1) ? 0 : 1))
                $display("FAIL lsb_underrun m%0d: got %0d expected %0d", m, und_n[m] - u0, (m % 2 == 1) ? 0 : 1);
            else passed++;
        end
    endtask

    task automatic test_overrun();
        logic [15:0] rd;
        int lat, o0;
        rx_ready[0] = 1'b0;
        o0 = ovr_n[0];
        cs_on(0);
        xfer(0, 8, 16'h0011, rd, lat);
        xfer(0, 8, 16'h0022, rd, lat);
        cs_off(0);
        total++;
        if (rx_valid[0] !== 1'b1 || rx_w[0] !== 16'h0011)
            $display("FAIL overrun_rx: got valid=%b data=%h expected valid=1 data=0011", rx_valid[0], rx_w[0]);
        else passed++;
        total++;
        if (ovr_n[0] - o0 !== 1) $display("FAIL overrun_count: got %0d expected 1", ovr_n[0] - o0); else passed++;
        rx_ready[0] = 1'b1;
        wait_clk(2);
        rx_ready[0] = 1'b0;
        total++;
        if (rx_valid[0] !== 1'b0) $display("FAIL overrun_consume: got %b expected 0", rx_valid[0]); else passed++;
    endtask

    task automatic test_underrun();
        logic [15:0] rd;
        int lat, u0;
        rx_ready[0] = 1'b1;
        total++;
        if (tx_ready[0] !== 1'b1) $display("FAIL underrun_empty: tx_ready got %b expected 1", tx_ready[0]); else passed++;
        u0 = und_n[0];
        cs_on(0);
        total++;
        if (und_n[0] - u0 !== 1) $display("FAIL underrun_start: got %0d expected 1", und_n[0] - u0); else passed++;
        xfer(0, 8, 16'h00C7, rd, lat);
        cs_off(0);
        total++;
        if (rd !== 16'h0000) $display("FAIL underrun_miso: got %h expected 0000", rd); else passed++;
        total++;
        if (und_n[0] - u0 !== 2) $display("FAIL underrun_total: got %0d expected 2", und_n[0] - u0); else passed++;
    endtask

    task automatic test_frame_err();
        logic [15:0] rd;
        int lat, f0;
        rx_ev_t ev;
        rx_ready[0] = 1'b1;
        rxq.delete();
        f0 = fer_n[0];
        cs_on(0);
        offer(0, 16'h00C3);
        xfer(0, 5, 16'h00FF, rd, lat);
        cs_off(0);
        total++;
        if (fer_n[0] - f0 !== 1) $display("FAIL frame_err_pulse: got %0d expected 1", fer_n[0] - f0); else passed++;
        total++;
        if (rxq.size() != 0 || rx_valid[0] !== 1'b0)
            $display("FAIL frame_err_norx: got %0d words valid=%b expected 0 words valid=0", rxq.size(), rx_valid[0]);
        else passed++;
        total++;
        if (tx_ready[0] !== 1'b0) $display("FAIL frame_err_hold_kept: tx_ready got %b expected 0", tx_ready[0]); else passed++;
        cs_on(0);
        xfer(0, 8, 16'h005A, rd, lat);
        cs_off(0);
        total++;
        if (rd !== 16'h00C3) $display("FAIL frame_err_next_miso: got %h expected 00c3", rd); else passed++;
        total++;
        if (rxq.size() == 0) $display("FAIL frame_err_next_rx: got no word expected 005a");
        else begin
            ev = rxq.pop_front();
            if (ev.data !== 16'h005A) $display("FAIL frame_err_next_rx: got %h expected 005a", ev.data);
            else passed++;
        end
        total++;
        if (fer_n[0] - f0 !== 1) $display("FAIL frame_err_clean: got %0d expected 1", fer_n[0] - f0); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        int lat, f0;
        rx_ev_t ev;
        rx_ready[0] = 1'b0;
        f0 = fer_n[0];
        cs_on(0);
        offer(0, 16'h0044);
        xfer(0, 4, 16'h00F0, rd, lat);
        rst_n = 1'b0;
        #1;
        total++;
        if ({miso[0], rx_valid[0], busy[0], overrun[0], underrun[0], frame_err[0], tx_ready[0]} !== 7'b0000001)
            $display("FAIL reset_mid_flags: got %b expected 0000001",
                     {miso[0], rx_valid[0], busy[0], overrun[0], underrun[0], frame_err[0], tx_ready[0]});
        else passed++;
        total++;
        if (rx_w[0] !== 16'h0000) $display("FAIL reset_mid_rx_data: got %h expected 0000", rx_w[0]); else passed++;
        cs_n[0] = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(20);
        total++;
        if (rx_valid[0] !== 1'b0 || fer_n[0] - f0 !== 0)
            $display("FAIL reset_mid_quiet: got valid=%b ferr=%0d expected 0 0", rx_valid[0], fer_n[0] - f0);
        else passed++;
        rx_ready[0] = 1'b1;
        rxq.delete();
        offer(0, 16'h0069);
        cs_on(0);
        xfer(0, 8, 16'h0096, rd, lat);
        cs_off(0);
        total++;
        if (rd !== 16'h0069) $display("FAIL reset_mid_resume_miso: got %h expected 0069", rd); else passed++;
        total++;
        if (rxq.size() == 0) $display("FAIL reset_mid_resume_rx: got no word expected 0096");
        else begin
            ev = rxq.pop_front();
            if (ev.data !== 16'h0096) $display("FAIL reset_mid_resume_rx: got %h expected 0096", ev.data);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [15:0] mask, rd, tmp;
        logic [15:0] wo [3];
        logic [15:0] tw [3];
        logic [15:0] exp_rd [3];
        int n, u0, o0, lat;
        rx_ev_t ev;
        rxq.delete();
        for (int m = 0; m < 4; m++) begin
            mh_full[m] = 1'b0;
            rx_ready[m] = 1'b1;
        end
        for (int m = 0; m < 4; m++) begin
            mask = (m == 0) ? 16'h00FF : 16'hFFFF;
            for (int f = 0; f < 3; f++) begin
                n = $urandom_range(3, 1);
                for (int k = 0; k < n; k++) begin
                    wo[k] = 16'($urandom) & mask;
                    tw[k] = 16'($urandom) & mask;
                end
                mdl_und = 0;
                u0 = und_n[m];
                o0 = ovr_n[m];
                if (m % 2 == 0) begin
                    mdl_offer(m, tw[0]);
                    exp_rd[0] = mdl_load(m);
                    offer(m, tw[0]);
                end
                cs_on(m);
                total++;
                if (busy[m] !== 1'b1) $display("FAIL rand_busy m%0d: got %b expected 1", m, busy[m]); else passed++;
                for (int k = 0; k < n; k++) begin
                    if (m % 2 == 0) begin
                        if (k + 1 < n) begin
                            mdl_offer(m, tw[k + 1]);
                            offer(m, tw[k + 1]);
                        end
                    end else begin
                        mdl_offer(m, tw[k]);
                        exp_rd[k] = mdl_load(m);
                        offer(m, tw[k]);
                    end
                    xfer(m, wbits(m), wo[k], rd, lat);
                    if (m % 2 == 0) begin
                        tmp = mdl_load(m);
                        if (k + 1 < n) exp_rd[k + 1] = tmp;
                    end
                    total++;
                    if (rd !== exp_rd[k]) $display("FAIL rand_miso m%0d w%0d: got %h expected %h", m, k, rd, exp_rd[k]);
                    else passed++;
                end
                cs_off(m);
                for (int k = 0; k < n; k++) begin
                    total++;
                    if (rxq.size() == 0) $display("FAIL rand_rx m%0d w%0d: got no word expected %h", m, k, wo[k]);
                    else begin
                        ev = rxq.pop_front();
                        if (ev.inst !== 2'(m) || ev.data !== wo[k])
                            $display("FAIL rand_rx m%0d w%0d: got inst=%0d data=%h expected %h", m, k, ev.inst, ev.data, wo[k]);
                        else passed++;
                    end
                end
                total++;
                if (und_n[m] - u0 !== mdl_und || ovr_n[m] - o0 !== 0)
                    $display("FAIL rand_flags m%0d: got und=%0d ovr=%0d expected und=%0d ovr=0",
                             m, und_n[m] - u0, ovr_n[m] - o0, mdl_und);
                else passed++;
            end
        end
    endtask

    initial begin
        sck      = 4'b1100;
        mosi     = '0;
        cs_n     = '1;
        rx_ready = '0;
        tx_valid = '0;
        for (int i = 0; i < 4; i++) tx_d[i] = '0;
        test_reset();
        test_mode0();
        test_modes_lsb();
        test_overrun();
        test_underrun();
        test_frame_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, total);
        $fatal(1);
    end
endmodule
